// File: rtl/vga_sync_monitor.sv
// Receive-side VGA sync checker: measures line/frame timing against expected
// parameters, reports beam position, error pulses and lock status.
module vga_sync_monitor #(
  parameter int   H_TOTAL     = 800,
  parameter int   H_SYNC_W    = 96,
  parameter int   V_TOTAL     = 525,
  parameter int   V_SYNC_W    = 2,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2,
  parameter int   HW          = 12,
  parameter int   VW          = 11
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          H_SYNC,
  input  logic          V_SYNC,
  output logic [HW-1:0] h_pos,
  output logic [VW-1:0] v_pos,
  output logic          frame_start,
  output logic          locked,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [HW-1:0] meas_h_total,
  output logic [VW-1:0] meas_v_total
);

  localparam logic [HW-1:0] C_H_TOTAL  = HW'(H_TOTAL);
  localparam logic [HW-1:0] C_H_SYNC_W = HW'(H_SYNC_W);
  localparam logic [HW-1:0] C_H_TMO    = HW'(2 * H_TOTAL);
  localparam logic [VW-1:0] C_V_TOTAL  = VW'(V_TOTAL);
  localparam logic [VW-1:0] C_V_SYNC_W = VW'(V_SYNC_W);
  localparam logic [3:0]    C_LOCK     = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {ST_WAIT_VS, ST_MEASURE, ST_LOCKED} state_t;

  state_t        r_state;
  logic          r_hs1, r_hs2, r_vs1, r_vs2;
  logic [HW-1:0] r_h_pos, r_h_width, r_meas_h;
  logic [VW-1:0] r_v_pos, r_v_width, r_meas_v;
  logic [3:0]    r_good_cnt;
  logic          r_frame_bad, r_line_armed;
  logic          r_frame_start, r_locked, r_err;
  logic [1:0]    r_err_code;

  logic          w_hs1_act, w_hs2_act, w_vs1_act, w_vs2_act;
  logic          w_h_lead, w_v_lead, w_v_trail, w_active;
  logic [HW-1:0] w_h_pos_inc;
  logic          w_line_chk, w_line_fail, w_vtot_fail, w_vwid_fail, w_timeout;
  logic          w_frame_clean;

  assign w_hs1_act = (r_hs1 == SYNC_POL);
  assign w_hs2_act = (r_hs2 == SYNC_POL);
  assign w_vs1_act = (r_vs1 == SYNC_POL);
  assign w_vs2_act = (r_vs2 == SYNC_POL);
  assign w_h_lead  = w_hs1_act & ~w_hs2_act;
  assign w_v_lead  = w_vs1_act & ~w_vs2_act;
  assign w_v_trail = ~w_vs1_act & w_vs2_act;
  assign w_active  = (r_state != ST_WAIT_VS);

  // h_pos is cleared on the leading-edge cycle, so the period of the line
  // ending now is h_pos + 1.
  assign w_h_pos_inc = (r_h_pos == {HW{1'b1}}) ? r_h_pos : r_h_pos + HW'(1);

  assign w_line_chk    = w_active & w_h_lead & r_line_armed;
  assign w_line_fail   = w_line_chk & ((w_h_pos_inc != C_H_TOTAL) | (r_h_width != C_H_SYNC_W));
  assign w_vtot_fail   = w_active & w_v_lead & (r_v_pos != C_V_TOTAL);
  assign w_vwid_fail   = w_active & w_v_trail & (r_v_width != C_V_SYNC_W);
  assign w_timeout     = w_active & ~w_h_lead & (w_h_pos_inc >= C_H_TMO);
  // A line error on a coincident hsync edge belongs to the frame being closed.
  assign w_frame_clean = ~(r_frame_bad | w_line_fail | w_vtot_fail);

  always_ff @(posedge clk) begin
    if (!RESET) begin
      r_hs1         <= ~SYNC_POL;
      r_hs2         <= ~SYNC_POL;
      r_vs1         <= ~SYNC_POL;
      r_vs2         <= ~SYNC_POL;
      r_h_pos       <= '0;
      r_h_width     <= '0;
      r_v_pos       <= '0;
      r_v_width     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_hs1         <= H_SYNC;
      r_hs2         <= r_hs1;
      r_vs1         <= V_SYNC;
      r_vs2         <= r_vs1;
      r_frame_start <= w_v_lead;

      // The leading-edge cycle is the first active cycle of the pulse.
      if (w_h_lead) begin
        r_h_pos   <= '0;
        r_h_width <= HW'(1);
      end else begin
        r_h_pos <= w_h_pos_inc;
        if (w_hs1_act && r_h_width != {HW{1'b1}})
          r_h_width <= r_h_width + HW'(1);
      end

      if (w_v_lead) begin
        r_v_pos   <= w_h_lead ? VW'(1) : '0;
        r_v_width <= w_h_lead ? VW'(1) : '0;
      end else if (w_h_lead) begin
        if (r_v_pos != {VW{1'b1}})
          r_v_pos <= r_v_pos + VW'(1);
        if (w_vs1_act && r_v_width != {VW{1'b1}})
          r_v_width <= r_v_width + VW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      r_state      <= ST_WAIT_VS;
      r_good_cnt   <= '0;
      r_frame_bad  <= 1'b0;
      r_line_armed <= 1'b0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= 2'd0;
      r_meas_h     <= '0;
      r_meas_v     <= '0;
    end else begin
      r_err <= w_timeout | w_vtot_fail | w_vwid_fail | w_line_fail;
      if (w_timeout)        r_err_code <= 2'd3;
      else if (w_vtot_fail) r_err_code <= 2'd1;
      else if (w_vwid_fail) r_err_code <= 2'd2;
      else if (w_line_fail) r_err_code <= 2'd0;

      if (w_line_chk)
        r_meas_h <= w_h_pos_inc;
      if (w_line_fail || w_vwid_fail)
        r_frame_bad <= 1'b1;

      case (r_state)
        ST_WAIT_VS: begin
          if (w_v_lead) begin
            r_state      <= ST_MEASURE;
            r_good_cnt   <= '0;
            r_frame_bad  <= 1'b0;
            r_line_armed <= w_h_lead;
          end
        end
        ST_MEASURE, ST_LOCKED: begin
          if (w_h_lead)
            r_line_armed <= 1'b1;
          if (w_timeout) begin
            r_state      <= ST_WAIT_VS;
            r_locked     <= 1'b0;
            r_good_cnt   <= '0;
            r_frame_bad  <= 1'b0;
            r_line_armed <= 1'b0;
          end else if (w_v_lead) begin
            r_meas_v    <= r_v_pos;
            r_frame_bad <= 1'b0;
            if (!w_frame_clean) begin
              r_state    <= ST_MEASURE;
              r_locked   <= 1'b0;
              r_good_cnt <= '0;
            end else if (r_state == ST_MEASURE) begin
              r_good_cnt <= r_good_cnt + 4'd1;
              if (r_good_cnt + 4'd1 == C_LOCK) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_WAIT_VS;
      endcase
    end
  end

  assign h_pos        = r_h_pos;
  assign v_pos        = r_v_pos;
  assign frame_start  = r_frame_start;
  assign locked       = r_locked;
  assign err          = r_err;
  assign err_code     = r_err_code;
  assign meas_h_total = r_meas_h;
  assign meas_v_total = r_meas_v;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor: drives ideal and faulty sync streams
// and checks lock, error and measurement outputs against hand-derived values.
module tb_vga_sync_monitor;
  localparam int HT = 20, HSW = 4, VT = 10, VSW = 2, HW = 12, VW = 11;

  logic          clk = 1'b0;
  logic          RESET = 1'b0;
  logic          H_SYNC = 1'b1;
  logic          V_SYNC = 1'b1;
  logic [HW-1:0] h_pos, meas_h_total;
  logic [VW-1:0] v_pos, meas_v_total;
  logic          frame_start, locked, err;
  logic [1:0]    err_code;

  int n_tests = 0, n_fail = 0;
  int fs_count = 0, err_count = 0;
  logic fs_locked [0:127];
  int   fs_vpos   [0:127];
  logic [1:0] last_err_code;
  logic err_locked, err_fs;
  int   err_hpos, err_vpos, err_meas_h;
  logic vs_level = 1'b0;
  logic [2*HW+2*VW+4:0] rst_snap;

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_SYNC_W(HSW), .V_TOTAL(VT), .V_SYNC_W(VSW),
    .SYNC_POL(1'b0), .LOCK_FRAMES(2), .HW(HW), .VW(VW)
  ) dut (
    .clk(clk), .RESET(RESET), .H_SYNC(H_SYNC), .V_SYNC(V_SYNC),
    .h_pos(h_pos), .v_pos(v_pos), .frame_start(frame_start), .locked(locked),
    .err(err), .err_code(err_code), .meas_h_total(meas_h_total), .meas_v_total(meas_v_total)
  );

  always #5 clk = ~clk;

  // Event logger on the inactive edge; the test tasks compare what it records.
  always @(negedge clk) begin
    if (frame_start) begin
      fs_count = fs_count + 1;
      fs_locked[fs_count] = locked;
      fs_vpos[fs_count]   = int'(v_pos);
    end
    if (err) begin
      err_count     = err_count + 1;
      last_err_code = err_code;
      err_locked    = locked;
      err_fs        = frame_start;
      err_hpos      = int'(h_pos);
      err_vpos      = int'(v_pos);
      err_meas_h    = int'(meas_h_total);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input int period, input int vs_on, input int vs_off, input int rst_at);
    for (int c = 0; c < period; c++) begin
      if (c == vs_on)  vs_level = 1'b1;
      if (c == vs_off) vs_level = 1'b0;
      H_SYNC = (c < HSW) ? 1'b0 : 1'b1;
      V_SYNC = vs_level ? 1'b0 : 1'b1;
      RESET  = (c == rst_at) ? 1'b0 : 1'b1;
      tick();
      if (c == rst_at)
        rst_snap = {h_pos, v_pos, frame_start, locked, err, err_code, meas_h_total, meas_v_total};
    end
    RESET = 1'b1;
  endtask

  task automatic run_frame(input int nlines, input int bad_line, input int bad_period,
                           input bit coincident, input int rst_line);
    int p, on, off, vs_c;
    vs_c = coincident ? 0 : 10;
    for (int l = 0; l < nlines; l++) begin
      p   = (l == bad_line) ? bad_period : HT;
      on  = (l == 0) ? vs_c : -1;
      off = (l == VSW) ? vs_c : -1;
      run_line(p, on, off, (l == rst_line) ? 7 : -1);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; H_SYNC = 1'b1; V_SYNC = 1'b1; vs_level = 1'b0;
    repeat (3) tick();
    rst_snap = {h_pos, v_pos, frame_start, locked, err, err_code, meas_h_total, meas_v_total};
    n_tests++;
    if (rst_snap !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", rst_snap); end
    RESET = 1'b1;
    tick();
    n_tests++;
    if (locked !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_release: got locked=%b err=%b expected 0 0", locked, err); end
    $display("[TB] reset: outputs=%h", rst_snap);
  endtask

  task automatic test_ideal();
    int b, e;
    b = fs_count; e = err_count;
    repeat (3) run_frame(VT, -1, HT, 1'b0, -1);
    n_tests++;
    if (fs_count - b !== 3) begin n_fail++; $display("FAIL ideal_fs_count: got %0d expected 3", fs_count - b); end
    n_tests++;
    if (fs_locked[b+1] !== 1'b0 || fs_locked[b+2] !== 1'b0) begin n_fail++; $display("FAIL ideal_early_lock: got %b%b expected 00", fs_locked[b+1], fs_locked[b+2]); end
    n_tests++;
    if (fs_locked[b+3] !== 1'b1) begin n_fail++; $display("FAIL ideal_lock_3rd_fs: got %b expected 1", fs_locked[b+3]); end
    n_tests++;
    if (err_count !== e) begin n_fail++; $display("FAIL ideal_no_err: got %0d errors expected 0", err_count - e); end
    n_tests++;
    if (meas_h_total !== HW'(20)) begin n_fail++; $display("FAIL ideal_meas_h: got %0d expected 20", meas_h_total); end
    n_tests++;
    if (meas_v_total !== VW'(10)) begin n_fail++; $display("FAIL ideal_meas_v: got %0d expected 10", meas_v_total); end
    n_tests++;
    if (h_pos !== HW'(18) || v_pos !== VW'(9)) begin n_fail++; $display("FAIL ideal_pos: got h=%0d v=%0d expected h=18 v=9", h_pos, v_pos); end
    n_tests++;
    if (fs_vpos[b+3] !== 0) begin n_fail++; $display("FAIL ideal_fs_vpos: got %0d expected 0", fs_vpos[b+3]); end
    $display("[TB] ideal: frames=%0d locked=%b meas_h=%0d meas_v=%0d", fs_count - b, locked, meas_h_total, meas_v_total);
  endtask

  task automatic test_line_err();
    int b, e;
    b = fs_count; e = err_count;
    run_frame(VT, 4, 21, 1'b0, -1);
    n_tests++;
    if (err_count !== e + 1 || last_err_code !== 2'd0) begin n_fail++; $display("FAIL line_err_code: got n=%0d code=%0d expected n=1 code=0", err_count - e, last_err_code); end
    n_tests++;
    if (err_hpos !== 0 || err_vpos !== 5) begin n_fail++; $display("FAIL line_err_timing: got h=%0d v=%0d expected h=0 v=5", err_hpos, err_vpos); end
    n_tests++;
    if (err_locked !== 1'b1 || err_meas_h !== 21) begin n_fail++; $display("FAIL line_err_state: got locked=%b meas_h=%0d expected 1 21", err_locked, err_meas_h); end
    repeat (3) run_frame(VT, -1, HT, 1'b0, -1);
    n_tests++;
    if (fs_locked[b+1] !== 1'b1 || fs_locked[b+2] !== 1'b0 || fs_locked[b+3] !== 1'b0 || fs_locked[b+4] !== 1'b1)
      begin n_fail++; $display("FAIL line_err_relock: got %b%b%b%b expected 1001", fs_locked[b+1], fs_locked[b+2], fs_locked[b+3], fs_locked[b+4]); end
    n_tests++;
    if (err_count !== e + 1) begin n_fail++; $display("FAIL line_err_single: got %0d errors expected 1", err_count - e); end
    $display("[TB] line_err: code=%0d relocked=%b", last_err_code, locked);
  endtask

  task automatic test_vtotal_err();
    int b, e;
    b = fs_count; e = err_count;
    run_frame(VT + 1, -1, HT, 1'b0, -1);
    run_frame(VT, -1, HT, 1'b0, -1);
    n_tests++;
    if (err_count !== e + 1 || last_err_code !== 2'd1) begin n_fail++; $display("FAIL vtot_err_code: got n=%0d code=%0d expected n=1 code=1", err_count - e, last_err_code); end
    n_tests++;
    if (err_fs !== 1'b1 || err_locked !== 1'b0) begin n_fail++; $display("FAIL vtot_err_edge: got fs=%b locked=%b expected 1 0", err_fs, err_locked); end
    n_tests++;
    if (meas_v_total !== VW'(11)) begin n_fail++; $display("FAIL vtot_meas_v: got %0d expected 11", meas_v_total); end
    repeat (2) run_frame(VT, -1, HT, 1'b0, -1);
    n_tests++;
    if (fs_locked[b+1] !== 1'b1 || fs_locked[b+2] !== 1'b0 || fs_locked[b+3] !== 1'b0 || fs_locked[b+4] !== 1'b1)
      begin n_fail++; $display("FAIL vtot_relock: got %b%b%b%b expected 1001", fs_locked[b+1], fs_locked[b+2], fs_locked[b+3], fs_locked[b+4]); end
    $display("[TB] vtotal_err: code=%0d meas_v=%0d relocked=%b", last_err_code, meas_v_total, locked);
  endtask

  task automatic test_timeout();
    int b, e;
    e = err_count;
    H_SYNC = 1'b1; V_SYNC = 1'b1;
    repeat (100) tick();
    n_tests++;
    if (err_count !== e + 1 || last_err_code !== 2'd3) begin n_fail++; $display("FAIL timeout_code: got n=%0d code=%0d expected n=1 code=3", err_count - e, last_err_code); end
    n_tests++;
    if (err_hpos !== 40 || err_locked !== 1'b0 || locked !== 1'b0) begin n_fail++; $display("FAIL timeout_state: got h=%0d locked=%b/%b expected 40 0/0", err_hpos, err_locked, locked); end
    b = fs_count;
    repeat (3) run_frame(VT, -1, HT, 1'b0, -1);
    n_tests++;
    if (fs_locked[b+1] !== 1'b0 || fs_locked[b+2] !== 1'b0 || fs_locked[b+3] !== 1'b1)
      begin n_fail++; $display("FAIL timeout_relock: got %b%b%b expected 001", fs_locked[b+1], fs_locked[b+2], fs_locked[b+3]); end
    n_tests++;
    if (err_count !== e + 1) begin n_fail++; $display("FAIL timeout_quiet: got %0d errors expected 1", err_count - e); end
    $display("[TB] timeout: code=%0d h_at_err=%0d relocked=%b", last_err_code, err_hpos, locked);
  endtask

  task automatic test_reset_midframe();
    int b, e;
    b = fs_count; e = err_count;
    run_frame(VT, -1, HT, 1'b0, 5);
    n_tests++;
    if (rst_snap !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h expected 0", rst_snap); end
    repeat (3) run_frame(VT, -1, HT, 1'b0, -1);
    n_tests++;
    if (fs_locked[b+1] !== 1'b1 || fs_locked[b+2] !== 1'b0 || fs_locked[b+3] !== 1'b0 || fs_locked[b+4] !== 1'b1)
      begin n_fail++; $display("FAIL midreset_relock: got %b%b%b%b expected 1001", fs_locked[b+1], fs_locked[b+2], fs_locked[b+3], fs_locked[b+4]); end
    n_tests++;
    if (err_count !== e) begin n_fail++; $display("FAIL midreset_no_err: got %0d errors expected 0", err_count - e); end
    $display("[TB] reset_midframe: snap=%h relocked=%b", rst_snap, locked);
  endtask

  task automatic test_coincident();
    int b, e;
    RESET = 1'b0; H_SYNC = 1'b1; V_SYNC = 1'b1; vs_level = 1'b0;
    repeat (2) tick();
    RESET = 1'b1;
    tick();
    b = fs_count; e = err_count;
    repeat (3) run_frame(VT, -1, HT, 1'b1, -1);
    n_tests++;
    if (fs_vpos[b+1] !== 1 || fs_vpos[b+2] !== 1) begin n_fail++; $display("FAIL coinc_vpos: got %0d/%0d expected 1/1", fs_vpos[b+1], fs_vpos[b+2]); end
    n_tests++;
    if (err_count !== e) begin n_fail++; $display("FAIL coinc_no_err: got %0d errors expected 0", err_count - e); end
    n_tests++;
    if (fs_locked[b+2] !== 1'b0 || fs_locked[b+3] !== 1'b1) begin n_fail++; $display("FAIL coinc_lock: got %b%b expected 01", fs_locked[b+2], fs_locked[b+3]); end
    n_tests++;
    if (meas_v_total !== VW'(10) || v_pos !== VW'(10)) begin n_fail++; $display("FAIL coinc_lines: got meas=%0d v=%0d expected 10 10", meas_v_total, v_pos); end
    $display("[TB] coincident: vpos_at_fs=%0d locked=%b", fs_vpos[b+1], locked);
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_line_err();
    test_vtotal_err();
    test_timeout();
    test_reset_midframe();
    test_coincident();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
